despachador_destinos: RTL and testbench
=======================================

Name: despachador_destinos

Overview:
- Request dispatcher that sits upstream of the elevator car controller and drives the car's 3-bit destination input.
- Captures hall/cabin call buttons for floors -1, 1, 2 and 3 into a pending-request set.
- Picks the next target with a direction-preserving (SCAN) policy and presents it to the car.
- Uses the car's ocupado and piso outputs as the handshake to clear a request once the car has served it.

Parameters:
- ACK_TIMEOUT, 16: clk cycles to wait in EMITIR for ocupado to rise before abandoning the issue and retrying.
- N_PISOS, 4: number of floors. Fixed at 4; it exists only for documentation and assertions.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- botones  input  4  raw call buttons, asynchronous to clk. bit0 = floor -1, bit1 = 1, bit2 = 2, bit3 = 3.
- piso  input  2  current car floor. 00 = -1, 01 = 1, 10 = 2, 11 = 3.
- ocupado  input  1  car busy flag. 1 while travelling or doors open; 0 when idle.
- destino  output  3  target to the car. 0xx = floor code xx; 100 = no request.
- pendientes  output  4  pending-request lamps, same bit order as botones.
- sentido  output  1  preferred sweep direction. 1 = up, 0 = down.
- activo  output  1  high while a request is issued and not yet served.

Behaviour:
- Reset values (asynchronous): destino = 100, pendientes = 0000, sentido = 1, activo = 0, state = LIBRE, timeout counter = 0, synchronizer flops = 0.
- Input capture:
  - Each botones bit passes through a 2-flop synchronizer, then a rising-edge detector.
  - An edge sets the matching pendientes bit; a held button does not re-set it.
  - Latency from button edge to lamp: 3 clk cycles.
- Set wins over clear: if a set and a clear hit the same bit in the same cycle, the bit ends up set.
- Selection (combinational over pendientes, piso, sentido):
  - sentido = 1: take the nearest pending floor strictly above piso. If none, take the nearest strictly below and flip sentido to 0.
  - sentido = 0: mirror of the above.
  - A request at piso itself is never chosen; it is handled in LIBRE (below).
- State LIBRE:
  - destino = 100, activo = 0.
  - If ocupado = 0 and the pendientes bit at piso is set: clear that bit and stay in LIBRE. The car is already there, so no issue is made.
  - Else, if ocupado = 0 and another request exists: register the selected floor into objetivo, drive destino = {0, objetivo}, set activo = 1, go to EMITIR.
  - If ocupado = 1 (car still finishing a previous job): stay in LIBRE.
- State EMITIR:
  - Hold destino; increment the counter.
  - ocupado = 1: clear the counter, go to VIAJE.
  - Counter reaches ACK_TIMEOUT: set destino = 100, activo = 0, go to LIBRE. The request stays pending and is retried.
- State VIAJE:
  - Hold destino constant; it must not change mid-trip.
  - New requests are still captured into pendientes.
  - When ocupado falls (registered 1 -> 0) and piso == objetivo: clear pendientes[objetivo], set destino = 100, activo = 0, go to LIBRE.
  - If ocupado falls with piso != objetivo: go to LIBRE without clearing, so the request is re-issued.
- No other outputs change in these states except as listed.
- Between two consecutive issues there is at least one LIBRE cycle with destino = 100.
- Floor code and pendientes index are identical: floor -1 = index 0, floor 3 = index 3. No arithmetic beyond 2-bit unsigned compare.
- Reset mid-trip: all requests are lost and destino returns to 100 immediately. The car then sees "no request" and settles.

Decomposition:
- Shared package ascensor_pkg holds:
  - floor codes PISO_MENOS_UNO = 2'b00, PISO_UNO, PISO_DOS, PISO_TRES;
  - DESTINO_NADA = 3'b100;
  - direction codes DIR_NADA, DIR_ARRIBA, DIR_ABAJO;
  - dispatcher state encoding LIBRE, EMITIR, VIAJE.
- One sub-module: selector_destino, a pure combinational SCAN picker. Inputs pendientes, piso, sentido; outputs valido, objetivo[1:0], nuevo_sentido.
- Synchronizer and edge detect stay inline.

Test Plan:
- Reset, then press botones = 1000 with piso = 01 and ocupado = 0:
  - pendientes = 1000 after 3 cycles;
  - destino = 011 and activo = 1 next cycle.
  - Then assert ocupado; raise piso to 11; drop ocupado: pendientes = 0000, destino = 100.
- Car at piso = 10, requests at floors 3 and -1, sentido = 1:
  - first issue destino = 011;
  - after it is served, next issue destino = 000 and sentido = 0.
- Press the button for the current floor (piso = 01) while ocupado = 0: the bit sets then clears; destino stays 100 throughout.
- Issue with ocupado held 0:
  - after ACK_TIMEOUT = 16 cycles, destino = 100 and activo = 0;
  - pendientes is unchanged and the next LIBRE cycle re-issues the same destino.
- During VIAJE to 011, press floor 2: destino stays 011 until served, then 010 is issued.
- Assert rst in VIAJE: destino = 100, pendientes = 0000, sentido = 1 asynchronously, without waiting for a clk edge.

Source files
------------

// File: rtl/ascensor_pkg.sv
// Shared encodings for the elevator request dispatcher: floor codes, the
// "no request" destination, sweep directions and dispatcher states.
package ascensor_pkg;

  typedef enum logic [1:0] {
    PISO_MENOS_UNO = 2'b00,
    PISO_UNO       = 2'b01,
    PISO_DOS       = 2'b10,
    PISO_TRES      = 2'b11
  } piso_t;

  localparam logic [2:0] DESTINO_NADA = 3'b100;

  typedef enum logic [1:0] {
    DIR_NADA,
    DIR_ARRIBA,
    DIR_ABAJO
  } dir_t;

  typedef enum logic [1:0] {
    LIBRE,
    EMITIR,
    VIAJE
  } estado_t;

  // Floor code and destination code differ only by the "no request" flag bit.
  function automatic logic [2:0] destino_de(input logic [1:0] p);
    return {1'b0, p};
  endfunction

endpackage

// File: rtl/selector_destino.sv
// Combinational SCAN picker: nearest pending floor in the current sweep
// direction, reversing only when nothing is left ahead of the car.
module selector_destino
  import ascensor_pkg::*;
(
  input  logic [3:0] pendientes,
  input  logic [1:0] piso,
  input  logic       sentido,
  output logic       valido,
  output logic [1:0] objetivo,
  output logic       nuevo_sentido
);

  logic       hay_arriba;
  logic       hay_abajo;
  logic [1:0] cerca_arriba;
  logic [1:0] cerca_abajo;
  dir_t       dir;

  // NOTE: every variable written in an always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    hay_arriba   = 1'b0;
    hay_abajo    = 1'b0;
    cerca_arriba = '0;
    cerca_abajo  = '0;
    // Scan order makes the last hit the nearest one in each direction.
    for (int i = 3; i >= 0; i--) begin
      if (pendientes[i] && (2'(i) > piso)) begin
        hay_arriba   = 1'b1;
        cerca_arriba = 2'(i);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (pendientes[i] && (2'(i) < piso)) begin
        hay_abajo   = 1'b1;
        cerca_abajo = 2'(i);
      end
    end
  end

  always_comb begin
    dir = DIR_NADA;
    if (sentido) begin
      if (hay_arriba)     dir = DIR_ARRIBA;
      else if (hay_abajo) dir = DIR_ABAJO;
    end else begin
      if (hay_abajo)       dir = DIR_ABAJO;
      else if (hay_arriba) dir = DIR_ARRIBA;
    end
  end

  assign valido        = (dir != DIR_NADA);
  assign objetivo      = (dir == DIR_ABAJO) ? cerca_abajo : cerca_arriba;
  assign nuevo_sentido = (dir == DIR_ARRIBA) ? 1'b1 :
                         (dir == DIR_ABAJO)  ? 1'b0 : sentido;

endmodule

// File: rtl/despachador_destinos.sv
// Request dispatcher for the elevator car: latches call buttons, issues one
// SCAN-selected destination at a time and clears it once the car arrives.
module despachador_destinos
  import ascensor_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int N_PISOS     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_PISOS-1:0] botones,
  input  logic [1:0]         piso,
  input  logic               ocupado,
  output logic [2:0]         destino,
  output logic [N_PISOS-1:0] pendientes,
  output logic               sentido,
  output logic               activo
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  logic [N_PISOS-1:0] sync1, sync2, previo, flanco, limpiar;
  logic               ocupado_q;
  estado_t            estado, estado_d;
  logic [1:0]         objetivo, objetivo_d;
  logic [CW-1:0]      contador, contador_d;
  logic [2:0]         destino_d;
  logic               sentido_d, activo_d;

  logic               sel_valido;
  logic [1:0]         sel_objetivo;
  logic               sel_sentido;

  selector_destino u_selector (
    .pendientes    (pendientes),
    .piso          (piso),
    .sentido       (sentido),
    .valido        (sel_valido),
    .objetivo      (sel_objetivo),
    .nuevo_sentido (sel_sentido)
  );

  assign flanco = sync2 & ~previo;

  always_comb begin
    estado_d   = estado;
    objetivo_d = objetivo;
    contador_d = contador;
    destino_d  = destino;
    sentido_d  = sentido;
    activo_d   = activo;
    limpiar    = '0;
    unique case (estado)
      LIBRE: begin
        destino_d = DESTINO_NADA;
        activo_d  = 1'b0;
        if (!ocupado) begin
          if (pendientes[piso]) begin
            limpiar[piso] = 1'b1;
          end else if (sel_valido) begin
            objetivo_d = sel_objetivo;
            sentido_d  = sel_sentido;
            destino_d  = destino_de(sel_objetivo);
            activo_d   = 1'b1;
            contador_d = '0;
            estado_d   = EMITIR;
          end
        end
      end
      EMITIR: begin
        if (ocupado) begin
          contador_d = '0;
          estado_d   = VIAJE;
        end else if (contador == CW'(ACK_TIMEOUT - 1)) begin
          contador_d = '0;
          destino_d  = DESTINO_NADA;
          activo_d   = 1'b0;
          estado_d   = LIBRE;
        end else begin
          contador_d = contador + 1'b1;
        end
      end
      VIAJE: begin
        if (ocupado_q && !ocupado) begin
          if (piso == objetivo) limpiar[objetivo] = 1'b1;
          destino_d = DESTINO_NADA;
          activo_d  = 1'b0;
          estado_d  = LIBRE;
        end
      end
      default: estado_d = LIBRE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1      <= '0;
      sync2      <= '0;
      previo     <= '0;
      ocupado_q  <= 1'b0;
      estado     <= LIBRE;
      objetivo   <= '0;
      contador   <= '0;
      destino    <= DESTINO_NADA;
      pendientes <= '0;
      sentido    <= 1'b1;
      activo     <= 1'b0;
    end else begin
      sync1      <= botones;
      sync2      <= sync1;
      previo     <= sync2;
      ocupado_q  <= ocupado;
      estado     <= estado_d;
      objetivo   <= objetivo_d;
      contador   <= contador_d;
      destino    <= destino_d;
      sentido    <= sentido_d;
      activo     <= activo_d;
      // A fresh press on the same cycle as its clear keeps the lamp lit.
      pendientes <= (pendientes & ~limpiar) | flanco;
    end
  end

endmodule

// File: tb/tb_despachador_destinos.sv
// Directed bench for despachador_destinos: expected issues are queued as
// buttons are pressed and popped when the dispatcher presents a destination.
module tb_despachador_destinos;
  import ascensor_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] botones = '0;
  logic [1:0] piso = 2'b01;
  logic       ocupado = 1'b0;
  logic [2:0] destino;
  logic [3:0] pendientes;
  logic       sentido;
  logic       activo;

  int total = 0;
  int bad   = 0;
  logic [2:0] sb[$];

  despachador_destinos #(.ACK_TIMEOUT(16), .N_PISOS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .botones    (botones),
    .piso       (piso),
    .ocupado    (ocupado),
    .destino    (destino),
    .pendientes (pendientes),
    .sentido    (sentido),
    .activo     (activo)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the next issue and compares it with the oldest queued expectation.
  task automatic wait_issue(input string tag, input int budget);
    logic [2:0] exp;
    int n;
    exp = DESTINO_NADA;
    if (sb.size() > 0) exp = sb.pop_front();
    n = 0;
    while (destino === DESTINO_NADA && n < budget) begin
      tick();
      n++;
    end
    check({tag, " destino"}, 32'(destino), 32'(exp));
    check({tag, " activo"}, 32'(activo), 32'd1);
  endtask

  task automatic serve(input logic [1:0] llegada);
    ocupado = 1'b1;
    tick();
    piso = llegada;
    tick();
    ocupado = 1'b0;
    tick();
  endtask

  initial begin
    // Asynchronous reset, checked before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst destino", 32'(destino), 32'(3'b100));
    check("rst pendientes", 32'(pendientes), 32'd0);
    check("rst sentido", 32'(sentido), 32'd1);
    check("rst activo", 32'(activo), 32'd0);
    tick(2);
    rst = 1'b0;

    // 1: call to floor 3 from floor 1, three-cycle lamp latency then issue.
    piso = 2'b01;
    botones = 4'b1000;
    sb.push_back(3'b011);
    tick(2);
    check("t1 lamp early", 32'(pendientes), 32'd0);
    tick();
    check("t1 lamp", 32'(pendientes), 32'(4'b1000));
    check("t1 idle destino", 32'(destino), 32'(3'b100));
    wait_issue("t1 issue", 1);
    botones = '0;
    ocupado = 1'b1;
    tick();
    piso = 2'b11;
    tick();
    check("t1 trip destino", 32'(destino), 32'(3'b011));
    ocupado = 1'b0;
    tick();
    check("t1 served pend", 32'(pendientes), 32'd0);
    check("t1 served destino", 32'(destino), 32'(3'b100));
    check("t1 served activo", 32'(activo), 32'd0);

    // 2: from floor 2 going up, floors 3 and -1 pending: up first, then reverse.
    piso = 2'b10;
    botones = 4'b1001;
    sb.push_back(3'b011);
    sb.push_back(3'b000);
    wait_issue("t2 first", 6);
    check("t2 first sentido", 32'(sentido), 32'd1);
    botones = '0;
    serve(2'b11);
    check("t2 gap destino", 32'(destino), 32'(3'b100));
    check("t2 gap pend", 32'(pendientes), 32'(4'b0001));
    wait_issue("t2 second", 3);
    check("t2 second sentido", 32'(sentido), 32'd0);
    serve(2'b00);
    check("t2 done pend", 32'(pendientes), 32'd0);

    // 3: call at the car's own floor is cleared without an issue.
    piso = 2'b01;
    botones = 4'b0010;
    tick(3);
    check("t3 lamp", 32'(pendientes), 32'(4'b0010));
    check("t3 destino a", 32'(destino), 32'(3'b100));
    tick();
    check("t3 cleared", 32'(pendientes), 32'd0);
    check("t3 destino b", 32'(destino), 32'(3'b100));
    botones = '0;
    tick(2);
    check("t3 destino c", 32'(destino), 32'(3'b100));
    check("t3 activo", 32'(activo), 32'd0);

    // 4: issue never acknowledged; abandon after 16 cycles and retry.
    botones = 4'b0100;
    sb.push_back(3'b010);
    wait_issue("t4 issue", 6);
    check("t4 sentido", 32'(sentido), 32'd1);
    botones = '0;
    tick(15);
    check("t4 still issued", 32'(destino), 32'(3'b010));
    tick();
    check("t4 timeout destino", 32'(destino), 32'(3'b100));
    check("t4 timeout activo", 32'(activo), 32'd0);
    check("t4 timeout pend", 32'(pendientes), 32'(4'b0100));
    sb.push_back(3'b010);
    wait_issue("t4 retry", 1);
    serve(2'b10);
    check("t4 served pend", 32'(pendientes), 32'd0);

    // 5: request for floor 2 during a trip to 3 does not disturb destino.
    botones = 4'b1000;
    sb.push_back(3'b011);
    wait_issue("t5 issue", 6);
    botones = '0;
    ocupado = 1'b1;
    tick();
    botones = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t5 hold %0d", i), 32'(destino), 32'(3'b011));
    end
    check("t5 lamps", 32'(pendientes), 32'(4'b1100));
    botones = '0;
    piso = 2'b11;
    tick();
    ocupado = 1'b0;
    tick();
    check("t5 served pend", 32'(pendientes), 32'(4'b0100));
    check("t5 served destino", 32'(destino), 32'(3'b100));
    sb.push_back(3'b010);
    wait_issue("t5 next", 3);
    check("t5 next sentido", 32'(sentido), 32'd0);

    // 6: reset mid-trip acts without a clock edge.
    ocupado = 1'b1;
    tick();
    check("t6 trip destino", 32'(destino), 32'(3'b010));
    #2 rst = 1'b1;
    #1;
    check("t6 rst destino", 32'(destino), 32'(3'b100));
    check("t6 rst pend", 32'(pendientes), 32'd0);
    check("t6 rst sentido", 32'(sentido), 32'd1);
    check("t6 rst activo", 32'(activo), 32'd0);
    tick();
    rst = 1'b0;
    ocupado = 1'b0;
    tick(3);
    check("t6 settled destino", 32'(destino), 32'(3'b100));
    check("t6 queue drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
